// File: rtl/hex_tx_formatter.sv
// rtl/hex_tx_formatter.sv - queues 32-bit values and prints each as "\n" plus 8 hex digits to a UART, with single-byte echo
module hex_tx_formatter #(
  parameter int FIFO_DEPTH = 4,
  parameter int LOWERCASE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        value_valid,
  output logic        value_ready,
  input  logic [7:0]  echo_data,
  input  logic        echo_valid,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, NL, DIG, HOLD} state_t;

  state_t      state;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] shift;
  logic [3:0]  count;
  logic        echo_pending;
  logic [7:0]  echo_byte;
  logic        full, empty, push, pop, echo_send;

  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty       = (wr_ptr == rd_ptr);
  assign value_ready = !full;
  assign push        = value_valid && !full;
  // IDLE acts only on a free transmitter, so values stay queued while it is blocked
  assign echo_send   = (state == IDLE) && !tx_busy && echo_pending;
  assign pop         = (state == IDLE) && !tx_busy && !echo_pending && !empty;
  assign busy        = (state != IDLE) || !empty || echo_pending;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else if (LOWERCASE != 0) return 8'h57 + {4'h0, n};
    else return 8'h37 + {4'h0, n};
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift       <= '0;
      count       <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      case (state)
        IDLE: begin
          if (echo_send) begin
            tx_data     <= echo_byte;
            new_tx_data <= 1'b1;
            count       <= '0;
            state       <= HOLD;
          end else if (pop) begin
            shift <= mem[rd_ptr[AW-1:0]];
            count <= 4'd8;
            state <= NL;
          end
        end
        NL: begin
          if (!tx_busy) begin
            tx_data     <= 8'h0A;
            new_tx_data <= 1'b1;
            state       <= HOLD;
          end
        end
        DIG: begin
          if (!tx_busy) begin
            tx_data     <= hex_char(shift[31:28]);
            new_tx_data <= 1'b1;
            shift       <= {shift[27:0], 4'h0};
            count       <= count - 4'd1;
            state       <= HOLD;
          end
        end
        // tx_busy rises one cycle after the strobe; skipping a cycle keeps us from re-sending on stale idle
        HOLD:    state <= (count != 4'd0) ? DIG : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_pending <= 1'b0;
      echo_byte    <= '0;
      drop_cnt     <= '0;
    end else if (echo_valid && (!echo_pending || echo_send)) begin
      echo_pending <= 1'b1;
      echo_byte    <= echo_data;
    end else begin
      if (echo_send) echo_pending <= 1'b0;
      if (echo_valid && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: doc/hex_tx_formatter.md
HEX_TX_FORMATTER -- requirements
Module: hex_tx_formatter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued 32-bit values (power of two, at least 2).
REQ-002 SHALL have parameter LOWERCASE, default 1, meaning 1 emits a-f and 0 emits A-F.
REQ-003 SHALL have port clk, input, 1 bit: the system clock (50 MHz).
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port value, input, 32 bits: the value to print.
REQ-006 SHALL have port value_valid, input, 1 bit: value is offered this cycle.
REQ-007 SHALL have port value_ready, output, 1 bit: the FIFO can accept; a push occurs when valid&&ready.
REQ-008 SHALL have port echo_data, input, 8 bits: a received byte to echo.
REQ-009 SHALL have port echo_valid, input, 1 bit: a single-cycle strobe for echo_data.
REQ-010 SHALL have port tx_data, output, 8 bits: the byte to the UART transmitter.
REQ-011 SHALL have port new_tx_data, output, 1 bit: a one-cycle strobe that launches tx_data.
REQ-012 SHALL have port tx_busy, input, 1 bit: the transmitter is busy or blocked.
REQ-013 SHALL have port busy, output, 1 bit: high when state≠IDLE, the FIFO is non-empty, or an echo is pending.
REQ-014 SHALL have port drop_cnt, output, 8 bits: a saturating count of echo bytes discarded.

Function
REQ-015 SHALL buffer values in a FIFO_DEPTH-entry FIFO; value_ready = !full; a push attempted while full is not accepted and is not counted.
REQ-016 SHALL print each value as one line: "\n" (0x0A), then 8 hex digits MSB nibble first, with no suppression of leading zeros.
REQ-017 SHALL encode each digit as nibble+0x30 for 0-9, and as nibble+0x57 (LOWERCASE=1) or nibble+0x37 (LOWERCASE=0) for 10-15.
REQ-018 SHALL implement the states IDLE, NL, DIG, and HOLD.
REQ-019 In IDLE with an echo pending, SHALL send the echo byte and go to HOLD; otherwise, with the FIFO non-empty, SHALL pop into a 32-bit shift register, set digit count 8, and go to NL.
REQ-020 SHALL give an echo priority over starting a new line only in IDLE; an echo is never inserted inside a line.
REQ-021 In NL, when !tx_busy, SHALL drive tx_data=0x0A and new_tx_data=1 for one cycle, then go to HOLD.
REQ-022 In DIG, when !tx_busy, SHALL emit the digit for shift[31:28], shift left by 4, decrement the count, and go to HOLD.
REQ-023 HOLD SHALL last exactly one cycle, because tx_busy lags new_tx_data by one cycle; it then goes to DIG if count>0, else to IDLE.
REQ-024 SHALL never drive new_tx_data in consecutive cycles, and never while tx_busy=1.
REQ-025 SHALL register tx_data and new_tx_data; tx_data holds its last value between strobes.
REQ-026 SHALL hold at most one echo byte; an echo_valid arriving while one is pending is discarded and drop_cnt increments, saturating at 255.
REQ-027 An echo_valid in the same cycle the pending echo is sent SHALL be accepted into the freed slot.
REQ-028 A simultaneous FIFO push and pop SHALL be allowed when not full; occupancy stays unchanged.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the full/empty distinction SHALL use an extra pointer bit.
REQ-030 Latency: with tx_busy=0 and state IDLE, new_tx_data for "\n" SHALL assert 2 cycles after the accepted push (one cycle for the pop, one for NL).

Reset
REQ-031 On rst, SHALL set state=IDLE, FIFO empty, echo slot empty, tx_data=0, new_tx_data=0, value_ready=1, busy=0, and drop_cnt=0.
REQ-032 A reset asserted mid-line SHALL abort the line with no further strobes; queued values are lost.

Verification
REQ-033 Push 0x0012ABEF with LOWERCASE=1 and tx_busy modelled as 10 cycles after each strobe -> bytes 0A 30 30 31 32 61 62 65 66, then IDLE with busy=0.
REQ-034 Push 0xDEADBEEF with LOWERCASE=0 -> digits 44 45 41 44 42 45 45 46.
REQ-035 Hold tx_busy=1 and push 5 values with FIFO_DEPTH=4 -> value_ready=0 after the 4th push, the 5th is not accepted, and releasing tx_busy yields 4 lines in push order.
REQ-036 Send echo 0x41 mid-line, then 0x42 before 0x41 is sent -> 0x41 is emitted only after the line's last digit, 0x42 is dropped, and drop_cnt=1.
REQ-037 Assert rst after the 3rd digit of 0x11111111 with 2 values queued -> no strobe after reset, value_ready=1, and busy=0.
REQ-038 Bench SHALL check on every run that new_tx_data is never high for 2 consecutive cycles and never high while tx_busy=1.
